req_encoder: RTL and testbench

- Sequential N-to-log2(N) request encoder; the inverse of the team's 2-to-4 one-hot decoder.
- Captures request pulses into a sticky pending register and selects one pending line by priority.
- Presents the selected line as a binary index, plus a one-hot copy, on a valid/ready handshake.
- Sits between peripheral request lines and the consumer that services them; out_idx can feed a decoder directly.

---
 rtl/req_encoder.sv | 135 +++++++++++++
 tb/tb_req_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder.sv
// req_encoder: captures request pulses into sticky pending bits and grants one at a time.
// Define REQ_ENCODER_RR_EN for round-robin priority; otherwise the lowest index wins.
module req_encoder #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] pending;
    logic [N-1:0] clr;
    logic [N-1:0] rem;
    logic [N-1:0] onehot_nx;
    logic [W-1:0] sel_idle;
    logic [W-1:0] sel_hold;
    logic [W-1:0] idx_nx;
    logic         valid_nx;
    logic         hs;

    function automatic logic [N-1:0] to_onehot(input logic [W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef REQ_ENCODER_RR_EN
    logic [W-1:0] last_idx;

    // First set bit strictly after base, wrapping modulo N.
    function automatic logic [W-1:0] pick(input logic [N-1:0] v,
                                          input logic [W-1:0] base);
        logic [W-1:0] r;
        int           j;
        r = '0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(base) + k) % N;
            if (v[j]) r = W'(j);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx <= W'(N - 1);
        end else if (hs) begin
            last_idx <= out_idx;
        end
    end

    // After a handshake the pointer becomes out_idx, so chained grants start there.
    assign sel_idle = pick(pending, last_idx);
    assign sel_hold = pick(rem, out_idx);
`else
    function automatic logic [W-1:0] pick(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    assign sel_idle = pick(pending);
    assign sel_hold = pick(rem);
`endif

    assign hs   = out_valid & out_ready;
    assign clr  = hs ? out_onehot : '0;
    assign rem  = pending & ~out_onehot;
    assign busy = (|pending) | out_valid;

    always_comb begin
        state_nx  = state;
        valid_nx  = out_valid;
        idx_nx    = out_idx;
        onehot_nx = out_onehot;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    idx_nx    = sel_idle;
                    onehot_nx = to_onehot(sel_idle);
                    valid_nx  = 1'b1;
                    state_nx  = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    if (|rem) begin
                        idx_nx    = sel_hold;
                        onehot_nx = to_onehot(sel_hold);
                    end else begin
                        valid_nx  = 1'b0;
                        onehot_nx = '0;
                        state_nx  = IDLE;
                    end
                end
            end
            default: begin
                state_nx  = IDLE;
                valid_nx  = 1'b0;
                onehot_nx = '0;
            end
        endcase
    end

    // A request on the line being cleared this cycle survives (set wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
        end else begin
            state      <= state_nx;
            pending    <= (pending & ~clr) | req;
            out_valid  <= valid_nx;
            out_idx    <= idx_nx;
            out_onehot <= onehot_nx;
        end
    end

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: directed vector table, reset corners and random traffic
// checked against a transaction-level reference model.
module tb_req_encoder;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_idx;
    logic [N-1:0] out_onehot;
    logic         busy;

    int ntests = 0;
    int nfail  = 0;

    req_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_onehot(out_onehot),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: set of outstanding lines plus the current grant.
    logic [N-1:0] m_pend;
    bit           m_valid;
    int           m_idx;
`ifdef REQ_ENCODER_RR_EN
    int           m_last;

    function automatic int choose(input logic [N-1:0] v, input int after);
        for (int k = 1; k <= N; k++) begin
            if (v[(after + k) % N]) return (after + k) % N;
        end
        return 0;
    endfunction
`else
    function automatic int choose(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction
`endif

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 0;
        m_idx   = 0;
`ifdef REQ_ENCODER_RR_EN
        m_last  = N - 1;
`endif
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic rdy);
        logic [N-1:0] nxt;
        logic [N-1:0] left;
        bit           took;
        int           old;
        took = m_valid && rdy;
        old  = m_idx;
        nxt  = m_pend;
        if (took) nxt[old] = 1'b0;
        nxt = nxt | r;
        if (!m_valid) begin
            if (m_pend != 0) begin
`ifdef REQ_ENCODER_RR_EN
                m_idx = choose(m_pend, m_last);
`else
                m_idx = choose(m_pend);
`endif
                m_valid = 1;
            end
        end else if (took) begin
            left      = m_pend;
            left[old] = 1'b0;
`ifdef REQ_ENCODER_RR_EN
            m_last = old;
`endif
            if (left != 0) begin
`ifdef REQ_ENCODER_RR_EN
                m_idx = choose(left, old);
`else
                m_idx = choose(left);
`endif
            end else begin
                m_valid = 0;
            end
        end
        m_pend = nxt;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        logic [N-1:0] oh;
        oh = '0;
        if (m_valid) oh[m_idx] = 1'b1;
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".idx"}, 32'(out_idx), 32'(m_idx));
        check({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
        check({tag, ".busy"}, 32'(busy), 32'((m_pend != 0) || m_valid));
    endtask

    // Drive at negedge, let one rising edge pass, return at the next negedge.
    task automatic cyc(input logic [N-1:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        @(posedge clk);
        model_step(r, rdy);
        @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic         v;
        logic [1:0]   idx;
        logic [N-1:0] oh;
        logic         busy;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{4'b0100, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b1};
        tbl[1]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0};
        tbl[3]  = '{4'b1011, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1};
        tbl[4]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[5]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[6]  = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0100, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b1};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[10] = '{4'b0001, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[11] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[12] = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
        tbl[14] = '{4'b0010, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[15] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[16] = '{4'b0010, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b1};
        tbl[17] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[18] = '{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};

        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.onehot", 32'(out_onehot), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.idx", 32'(out_idx), 32'd0);

        rst_n = 1'b1;
        cyc(4'b1111, 1'b1);
        check("rel.edge1.valid", 32'(out_valid), 32'd0);
        check("rel.edge1.busy", 32'(busy), 32'd1);
        cyc(4'b0000, 1'b1);
        check("rel.edge2.valid", 32'(out_valid), 32'd1);
        check("rel.edge2.idx", 32'(out_idx), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0000, 1'b1);
            cmp_model("drain");
        end

`ifndef REQ_ENCODER_RR_EN
        foreach (tbl[i]) begin
            cyc(tbl[i].req, tbl[i].rdy);
            check($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d.idx", i), 32'(out_idx), 32'(tbl[i].idx));
            check($sformatf("tbl%0d.onehot", i), 32'(out_onehot), 32'(tbl[i].oh));
            check($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
        end
`endif

        // Reset asserted while a grant is held and more lines are pending.
        cyc(4'b0110, 1'b0);
        cyc(4'b0000, 1'b0);
        cmp_model("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check("midrst.valid", 32'(out_valid), 32'd0);
        check("midrst.onehot", 32'(out_onehot), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000, 1'b1);
            check("postrst.valid", 32'(out_valid), 32'd0);
        end

        // All lines held with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            cyc(4'b1111, 1'b1);
            cmp_model("hold_all");
        end
        for (int i = 0; i < 6; i++) begin
            cyc(4'b0000, 1'b1);
            cmp_model("hold_drain");
        end

        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r;
            logic         rdy;
            r   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rdy = ($urandom_range(0, 9) < 7);
            cyc(r, rdy);
            cmp_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
